// File: rtl/w6_pkg.sv
// Shared encodings for the priority-encoder family.
package w6_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/fixed_prio_scan.sv
// Combinational lowest-index-first scan: reports whether any bit is set,
// the position of the lowest set bit, and that position as a one-hot vector.
module fixed_prio_scan #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] index,
  output logic [N-1:0] onehot
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    found  = 1'b0;
    index  = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found     = 1'b1;
        index     = W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// N-input priority encoder with registered outputs; selects one request per
// clock using either fixed (MSB-first) or round-robin priority.
module rr_priority_encoder
  import w6_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant
);

  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;
  logic [N-1:0] req_masked;
  logic [N-1:0] req_rev;

  logic         m_found, u_found, f_found;
  logic [W-1:0] m_idx, u_idx, f_idx;
  logic [N-1:0] m_onehot, u_onehot, f_onehot;

  logic         next_valid;
  logic [W-1:0] next_idx;
  logic [N-1:0] next_grant;

  // Masked copy keeps only bits at or above ptr; reversed copy lets the
  // lowest-first scanner find the highest set bit for fixed priority.
  always_comb begin
    req_masked = '0;
    req_rev    = '0;
    for (int i = 0; i < N; i++) begin
      req_masked[i] = req[i] & (W'(i) >= ptr);
      req_rev[i]    = req[N-1-i];
    end
  end

  fixed_prio_scan #(.N(N)) u_scan_masked (
    .vec(req_masked), .found(m_found), .index(m_idx), .onehot(m_onehot)
  );

  fixed_prio_scan #(.N(N)) u_scan_full (
    .vec(req), .found(u_found), .index(u_idx), .onehot(u_onehot)
  );

  fixed_prio_scan #(.N(N)) u_scan_rev (
    .vec(req_rev), .found(f_found), .index(f_idx), .onehot(f_onehot)
  );

  always_comb begin
    next_valid = 1'b0;
    next_idx   = '0;
    next_grant = '0;
    ptr_next   = ptr;
    if (mode == MODE_RR) begin
      if (m_found) begin
        next_valid = 1'b1;
        next_idx   = m_idx;
        next_grant = m_onehot;
      end else if (u_found) begin
        next_valid = 1'b1;
        next_idx   = u_idx;
        next_grant = u_onehot;
      end
      // Wrap explicitly at N-1 so ptr never reaches N for non-power-of-two N.
      if (next_valid) begin
        ptr_next = (next_idx == W'(N - 1)) ? '0 : next_idx + W'(1);
      end
    end else if (f_found) begin
      next_valid = 1'b1;
      next_idx   = W'(N - 1) - f_idx;
      for (int i = 0; i < N; i++) begin
        next_grant[i] = f_onehot[N-1-i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      idx   <= '0;
      grant <= '0;
      ptr   <= '0;
    end else if (en) begin
      valid <= next_valid;
      idx   <= next_idx;
      grant <= next_grant;
      ptr   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: table-driven N=4 vectors plus
// hand-written sequences for N=5 wrap-around and mid-operation reset.
module tb_rr_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       started = 1'b0;

  logic       en4, mode4;
  logic [3:0] req4;
  logic       valid4;
  logic [1:0] idx4;
  logic [3:0] grant4;

  logic       en5, mode5;
  logic [4:0] req5;
  logic       valid5;
  logic [2:0] idx5;
  logic [4:0] grant5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_first;
    logic       en;
    logic       mode;
    logic [3:0] req;
    logic       exp_valid;
    logic [1:0] exp_idx;
    logic [3:0] exp_grant;
    logic [1:0] exp_ptr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_priority_encoder #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .req(req4),
    .valid(valid4), .idx(idx4), .grant(grant4)
  );

  rr_priority_encoder #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .req(req5),
    .valid(valid5), .idx(idx5), .grant(grant5)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic rf, input logic e, input logic m,
                        input logic [3:0] r, input logic v, input logic [1:0] i,
                        input logic [3:0] g, input logic [1:0] p);
    vec_t t;
    t.rst_first = rf; t.en = e; t.mode = m; t.req = r;
    t.exp_valid = v; t.exp_idx = i; t.exp_grant = g; t.exp_ptr = p;
    vecs.push_back(t);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    en4 = 1'b0; en5 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic e, input logic m, input logic [3:0] r);
    @(negedge clk);
    en4 = e; mode4 = m; req4 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus5(input logic e, input logic m, input logic [4:0] r);
    @(negedge clk);
    en5 = e; mode5 = m; req5 = r;
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("inv4_onehot", 32'((grant4 & (grant4 - 4'd1)) == 4'd0), 32'd1);
      checkOutput("inv4_valid", 32'(valid4), 32'(|grant4));
      checkOutput("inv4_pos", 32'(grant4), valid4 ? 32'(4'd1 << idx4) : 32'd0);
      checkOutput("inv5_onehot", 32'((grant5 & (grant5 - 5'd1)) == 5'd0), 32'd1);
      checkOutput("inv5_valid", 32'(valid5), 32'(|grant5));
      checkOutput("inv5_pos", 32'(grant5), valid5 ? 32'(5'd1 << idx5) : 32'd0);
      checkOutput("inv5_ptr_range", 32'(dut5.ptr < 3'd5), 32'd1);
    end
  end

  initial begin
    en4 = 1'b0; mode4 = 1'b0; req4 = '0;
    en5 = 1'b0; mode5 = 1'b0; req5 = '0;

    // Round-robin over all four requesters.
    addVec(1, 1, 1, 4'b1111, 1, 2'd0, 4'b0001, 2'd1);
    addVec(0, 1, 1, 4'b1111, 1, 2'd1, 4'b0010, 2'd2);
    addVec(0, 1, 1, 4'b1111, 1, 2'd2, 4'b0100, 2'd3);
    addVec(0, 1, 1, 4'b1111, 1, 2'd3, 4'b1000, 2'd0);
    addVec(0, 1, 1, 4'b1111, 1, 2'd0, 4'b0001, 2'd1);
    // Alternating sparse requesters.
    addVec(1, 1, 1, 4'b1010, 1, 2'd1, 4'b0010, 2'd2);
    addVec(0, 1, 1, 4'b1010, 1, 2'd3, 4'b1000, 2'd0);
    addVec(0, 1, 1, 4'b1010, 1, 2'd1, 4'b0010, 2'd2);
    // Fixed priority, then empty request.
    addVec(1, 1, 0, 4'b0110, 1, 2'd2, 4'b0100, 2'd0);
    addVec(0, 1, 0, 4'b0001, 1, 2'd0, 4'b0001, 2'd0);
    addVec(0, 1, 0, 4'b0000, 0, 2'd0, 4'b0000, 2'd0);
    // Idle cycles keep ptr, enable low holds everything.
    addVec(0, 1, 1, 4'b0010, 1, 2'd1, 4'b0010, 2'd2);
    addVec(0, 1, 1, 4'b0000, 0, 2'd0, 4'b0000, 2'd2);
    addVec(0, 1, 1, 4'b0000, 0, 2'd0, 4'b0000, 2'd2);
    addVec(0, 1, 1, 4'b1111, 1, 2'd2, 4'b0100, 2'd3);
    addVec(0, 0, 1, 4'b0001, 1, 2'd2, 4'b0100, 2'd3);
    addVec(0, 0, 0, 4'b1000, 1, 2'd2, 4'b0100, 2'd3);
    addVec(0, 0, 1, 4'b0000, 1, 2'd2, 4'b0100, 2'd3);
    // Mode switch retains ptr; single requests win regardless of ptr.
    addVec(0, 1, 0, 4'b1111, 1, 2'd3, 4'b1000, 2'd3);
    addVec(0, 1, 1, 4'b1111, 1, 2'd3, 4'b1000, 2'd0);
    addVec(0, 1, 1, 4'b0100, 1, 2'd2, 4'b0100, 2'd3);
    addVec(0, 1, 1, 4'b0001, 1, 2'd0, 4'b0001, 2'd1);
    addVec(0, 1, 0, 4'b0001, 1, 2'd0, 4'b0001, 2'd1);

    doReset();
    started = 1'b1;
    checkOutput("reset_valid", 32'(valid4), 32'd0);
    checkOutput("reset_idx", 32'(idx4), 32'd0);
    checkOutput("reset_grant", 32'(grant4), 32'd0);
    checkOutput("reset_ptr", 32'(dut4.ptr), 32'd0);

    foreach (vecs[k]) begin
      if (vecs[k].rst_first) doReset();
      applyStimulus(vecs[k].en, vecs[k].mode, vecs[k].req);
      checkOutput($sformatf("vec%0d_valid", k), 32'(valid4), 32'(vecs[k].exp_valid));
      checkOutput($sformatf("vec%0d_idx", k), 32'(idx4), 32'(vecs[k].exp_idx));
      checkOutput($sformatf("vec%0d_grant", k), 32'(grant4), 32'(vecs[k].exp_grant));
      checkOutput($sformatf("vec%0d_ptr", k), 32'(dut4.ptr), 32'(vecs[k].exp_ptr));
    end

    // N=5: ptr must wrap from 4 back to 0.
    doReset();
    applyStimulus5(1, 1, 5'b10001);
    checkOutput("n5_a_idx", 32'(idx5), 32'd0);
    checkOutput("n5_a_grant", 32'(grant5), 32'b00001);
    checkOutput("n5_a_ptr", 32'(dut5.ptr), 32'd1);
    applyStimulus5(1, 1, 5'b10001);
    checkOutput("n5_b_idx", 32'(idx5), 32'd4);
    checkOutput("n5_b_grant", 32'(grant5), 32'b10000);
    checkOutput("n5_b_ptr", 32'(dut5.ptr), 32'd0);
    applyStimulus5(1, 1, 5'b10001);
    checkOutput("n5_c_idx", 32'(idx5), 32'd0);
    checkOutput("n5_c_ptr", 32'(dut5.ptr), 32'd1);
    applyStimulus5(1, 0, 5'b01011);
    checkOutput("n5_fixed_idx", 32'(idx5), 32'd3);
    checkOutput("n5_fixed_ptr", 32'(dut5.ptr), 32'd1);
    applyStimulus5(1, 1, 5'b00101);
    checkOutput("n5_d_idx", 32'(idx5), 32'd2);
    checkOutput("n5_d_ptr", 32'(dut5.ptr), 32'd3);

    // Mid-operation asynchronous reset on the N=4 instance.
    doReset();
    applyStimulus(1, 1, 4'b1111);
    checkOutput("mid_a_idx", 32'(idx4), 32'd0);
    applyStimulus(1, 1, 4'b1111);
    checkOutput("mid_b_idx", 32'(idx4), 32'd1);
    checkOutput("mid_b_valid", 32'(valid4), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(valid4), 32'd0);
    checkOutput("async_idx", 32'(idx4), 32'd0);
    checkOutput("async_grant", 32'(grant4), 32'd0);
    checkOutput("async_ptr", 32'(dut4.ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_idx", 32'(idx4), 32'd0);
    checkOutput("post_rst_grant", 32'(grant4), 32'b0001);
    checkOutput("post_rst_valid", 32'(valid4), 32'd1);

    @(negedge clk);
    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
